rvx10_mc_controller: RTL and testbench
======================================

Name: rvx10_mc_controller

Overview:
- Multicycle control FSM that sequences the shared RVX10 datapath: one ALU, one unified instruction/data memory port, register file, IR/PC/data registers.
- Replaces single-cycle combinational control when the core moves to the multicycle organisation.
- Decodes RV32I subset (lw, sw, R-type, I-type ALU, beq, jal) plus RVX10 custom-0 ops, and drives per-state mux selects and write strobes.
- Stalls on a memory ready handshake.

Parameters:
- FETCH_ADR_SEL, 1'b0: AdrSrc value selecting PC as memory address; the complement selects ALUOut.
- ALU_W, 4: ALUControl width; fixed at 4 for the 15 RVX10 ALU operations.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- op  in  7  Instr[6:0] from IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- funct7lo  in  2  Instr[26:25], RVX10 group select
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 reg A
- ALUSrcB  out  2  00 reg B, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- ALUControl  out  4  ALU operation
- state_o  out  4  current state, for debug
- retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11.
- Reset (reset==0 at a clk edge):
  - State becomes FETCH.
  - While reset is low, PCWrite, IRWrite, MemWrite, RegWrite and retire are forced to 0.
  - All other outputs are 0 during reset.
  - Reset mid-instruction abandons the instruction with no partial write.
- Outputs are Moore decodes of state, except where noted. Unlisted selects are 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ImmSrc=10, add (precomputes the branch target).
  - Next state by op: 0000011/0100011 to MEMADR; 0110011/0001011 to EXECR; 0010011 to EXECI; 1100011 to BEQ; 1101111 to JAL; any other op is illegal (see Optional Feature).
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, add.
  - ImmSrc=00 for lw, 01 for sw.
  - Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle until mem_ready=1; then retire=1 and go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, then ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1, then FETCH.
- BEQ:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite=Zero (Mealy), retire=1, then FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1.
  - Then ALUWB, which writes rd=OldPC+4.
- ALUControl encoding: add 0000, sub 0001, and 0010, or 0011, slt 0101, andn 0110, orn 0111, xnor 1000, min 1001, max 1010, minu 1011, maxu 1100, rol 1101, ror 1110, abs 1111.
- EXECR/EXECI decode for op 0110011/0010011 by funct3:
  - 000: sub only if funct7b5=1 and op=0110011; otherwise add.
  - 010: slt. 110: or. 111: and.
  - Other funct3 values: add.
- EXECR decode for op 0001011, by funct7lo then funct3:
  - funct7lo 00: funct3 000 andn, 001 orn, 010 xnor.
  - funct7lo 01: funct3 000 min, 001 max, 010 minu, 011 maxu.
  - funct7lo 10: funct3 000 rol, 001 ror, 010 abs.
  - Unlisted combinations are illegal.
- Simultaneous events: mem_ready=1 in the same cycle as reset=0 is ignored; reset wins.

Optional Feature:
- Macro: RVX10_ILLEGAL_TRAP_EN.
- Defined: an illegal op or RVX10 combination in DECODE goes to TRAP. TRAP drives all strobes to 0, holds forever, and state_o reads 11; only reset exits.
- Undefined: an illegal instruction returns DECODE to FETCH as a NOP (PC already +4), with retire=1 in DECODE. The TRAP state is unreachable.

Test Plan:
- reset=0 for 2 cycles, then 1 with mem_ready=1:
  - During reset: all strobes 0, state_o=0.
  - First cycle after release: IRWrite=1, PCWrite=1, then DECODE.
- lw (op 0000011) with mem_ready low for 3 cycles in MEMREAD:
  - State sequence 0,1,2,3,3,3,3,4.
  - RegWrite=1 only in state 4; retire pulses once.
- RVX10 andn (op 0001011, funct7lo 00, funct3 000):
  - EXECR has ALUControl=0110, ALUSrcA=10, ALUSrcB=00.
  - ALUWB has RegWrite=1; total 4 cycles including FETCH.
- beq with Zero=1, then Zero=0:
  - PCWrite=1 in BEQ for the first, 0 for the second.
  - ALUControl=0001 in both.
- sw with mem_ready=0 for one cycle: MemWrite=1 for 2 cycles in MEMWRITE, AdrSrc=1, then FETCH.
- op 1111111:
  - With RVX10_ILLEGAL_TRAP_EN: state_o sticks at 11 with all strobes 0.
  - Without: the next state after DECODE is FETCH and retire=1.

Source files
------------

// File: rtl/rvx10_mc_controller_if.sv
// Control bundle between the RVX10 multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface rvx10_mc_controller_if #(
    parameter int ALU_W = 4
);
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [1:0]       funct7lo;
    logic             Zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             AdrSrc;
    logic             MemWrite;
    logic             IRWrite;
    logic [1:0]       ResultSrc;
    logic [1:0]       ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ImmSrc;
    logic             RegWrite;
    logic [ALU_W-1:0] ALUControl;
    logic [3:0]       state_o;
    logic             retire;

    modport master (
        input  op, funct3, funct7b5, funct7lo, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, state_o, retire
    );

    modport slave (
        output op, funct3, funct7b5, funct7lo, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegWrite, ALUControl, state_o, retire
    );
endinterface

// File: rtl/rvx10_mc_controller.sv
// Multicycle control FSM for the shared RVX10 datapath (RV32I subset + custom-0).
// Define RVX10_ILLEGAL_TRAP_EN to lock illegal instructions in TRAP instead of treating them as NOPs.
module rvx10_mc_controller #(
    parameter logic FETCH_ADR_SEL = 1'b0,
    parameter int   ALU_W         = 4
) (
    input logic                   clk,
    input logic                   reset,
    rvx10_mc_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_X   = 7'b0001011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_ANDN = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_ORN  = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_XNOR = 4'b1000;
    localparam logic [ALU_W-1:0] ALU_MIN  = 4'b1001;
    localparam logic [ALU_W-1:0] ALU_MAX  = 4'b1010;
    localparam logic [ALU_W-1:0] ALU_MINU = 4'b1011;
    localparam logic [ALU_W-1:0] ALU_MAXU = 4'b1100;
    localparam logic [ALU_W-1:0] ALU_ROL  = 4'b1101;
    localparam logic [ALU_W-1:0] ALU_ROR  = 4'b1110;
    localparam logic [ALU_W-1:0] ALU_ABS  = 4'b1111;

    state_t           state, next;
    logic [ALU_W-1:0] xalu, balu, execalu;
    logic             xvalid, illegal;

    // custom-0 group decode; xvalid also feeds the illegal-instruction check in DECODE
    always_comb begin
        xalu   = ALU_ADD;
        xvalid = 1'b1;
        case ({bus.funct7lo, bus.funct3})
            5'b00_000: xalu = ALU_ANDN;
            5'b00_001: xalu = ALU_ORN;
            5'b00_010: xalu = ALU_XNOR;
            5'b01_000: xalu = ALU_MIN;
            5'b01_001: xalu = ALU_MAX;
            5'b01_010: xalu = ALU_MINU;
            5'b01_011: xalu = ALU_MAXU;
            5'b10_000: xalu = ALU_ROL;
            5'b10_001: xalu = ALU_ROR;
            5'b10_010: xalu = ALU_ABS;
            default:   xvalid = 1'b0;
        endcase
    end

    // base RV32I ALU decode; bit 30 only means sub for register-register ops
    always_comb begin
        balu = ALU_ADD;
        case (bus.funct3)
            3'b000:  if (bus.funct7b5 && (bus.op == OP_R)) balu = ALU_SUB;
            3'b010:  balu = ALU_SLT;
            3'b110:  balu = ALU_OR;
            3'b111:  balu = ALU_AND;
            default: balu = ALU_ADD;
        endcase
    end

    assign execalu = (bus.op == OP_X) ? xalu : balu;

    always_ff @(posedge clk) begin
        if (!reset) state <= FETCH;
        else        state <= next;
    end

    // Moore output decode plus the few Mealy terms driven by mem_ready and Zero
    always_comb begin
        next           = state;
        illegal        = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.RegWrite   = 1'b0;
        bus.ALUControl = ALU_ADD;
        bus.retire     = 1'b0;
        bus.state_o    = state;
        case (state)
            FETCH: begin
                bus.AdrSrc    = FETCH_ADR_SEL;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.IRWrite   = bus.mem_ready;
                bus.PCWrite   = bus.mem_ready;
                if (bus.mem_ready) next = DECODE;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = 2'b10;
                case (bus.op)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECR;
                    OP_X:         if (xvalid) next = EXECR; else illegal = 1'b1;
                    OP_I:         next = EXECI;
                    OP_BEQ:       next = BEQ;
                    OP_JAL:       next = JAL;
                    default:      illegal = 1'b1;
                endcase
                if (illegal) begin
`ifdef RVX10_ILLEGAL_TRAP_EN
                    next = TRAP;
`else
                    next       = FETCH;
                    bus.retire = 1'b1;
`endif
                end
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ImmSrc  = (bus.op == OP_SW) ? 2'b01 : 2'b00;
                next        = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.AdrSrc = ~FETCH_ADR_SEL;
                if (bus.mem_ready) next = MEMWB;
            end
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
                bus.retire    = 1'b1;
                next          = FETCH;
            end
            MEMWRITE: begin
                bus.AdrSrc   = ~FETCH_ADR_SEL;
                bus.MemWrite = 1'b1;
                if (bus.mem_ready) begin
                    bus.retire = 1'b1;
                    next       = FETCH;
                end
            end
            EXECR: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = execalu;
                next           = ALUWB;
            end
            EXECI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = execalu;
                next           = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
                next         = FETCH;
            end
            BEQ: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = ALU_SUB;
                bus.PCWrite    = bus.Zero;
                bus.retire     = 1'b1;
                next           = FETCH;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                bus.PCWrite = 1'b1;
                next        = ALUWB;
            end
            TRAP:    next = TRAP;
            default: next = FETCH;
        endcase
        if (!reset) begin
            next           = FETCH;
            bus.PCWrite    = 1'b0;
            bus.AdrSrc     = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.ResultSrc  = 2'b00;
            bus.ALUSrcA    = 2'b00;
            bus.ALUSrcB    = 2'b00;
            bus.ImmSrc     = 2'b00;
            bus.RegWrite   = 1'b0;
            bus.ALUControl = ALU_ADD;
            bus.retire     = 1'b0;
            bus.state_o    = 4'd0;
        end
    end

endmodule

// File: tb/tb_rvx10_mc_controller.sv
// Directed bench for rvx10_mc_controller: each task walks one instruction through the FSM.
// Build with RVX10_ILLEGAL_TRAP_EN defined to check the trapping variant.
module tb_rvx10_mc_controller;

    typedef struct {
        logic [6:0] op;
        logic [1:0] f7lo;
        logic       f7b5;
        logic [2:0] f3;
        logic [3:0] alu;
        logic [3:0] st;
    } alu_vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] strobes;
    int         nCompared   = 0;
    int         nMismatched = 0;

    rvx10_mc_controller_if bus ();

    rvx10_mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign strobes = {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.retire};

    // inputs change 2 time units after the active edge; checks sample one unit later
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        repeat (2) tick();
        #1;
        nCompared++;
        if ({bus.state_o, strobes} !== 9'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_strobes got %b want %b", {bus.state_o, strobes}, 9'd0);
        end
        nCompared++;
        if ({bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl} !== 13'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_selects got %b want 0",
                     {bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl});
        end
        reset = 1'b1;
        #1;
        nCompared++;
        if ({bus.state_o, bus.IRWrite, bus.PCWrite, bus.ALUSrcB, bus.ResultSrc} !== {4'd0, 1'b1, 1'b1, 2'b10, 2'b10}) begin
            nMismatched++;
            $display("[TB] FAIL release_fetch got %b want %b",
                     {bus.state_o, bus.IRWrite, bus.PCWrite, bus.ALUSrcB, bus.ResultSrc}, {4'd0, 1'b1, 1'b1, 2'b10, 2'b10});
        end
        tick(); #1;
        nCompared++;
        if ({bus.state_o, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc} !== {4'd1, 2'b01, 2'b01, 2'b10}) begin
            nMismatched++;
            $display("[TB] FAIL decode got %b want %b",
                     {bus.state_o, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc}, {4'd1, 2'b01, 2'b01, 2'b10});
        end
        tick(); #1;
        nCompared++;
        if ({bus.state_o, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc} !== {4'd7, 2'b10, 2'b01, 2'b00}) begin
            nMismatched++;
            $display("[TB] FAIL execi got %b want %b",
                     {bus.state_o, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc}, {4'd7, 2'b10, 2'b01, 2'b00});
        end
        tick(); #1;
        nCompared++;
        if ({bus.state_o, strobes, bus.ResultSrc} !== {4'd8, 5'b00011, 2'b00}) begin
            nMismatched++;
            $display("[TB] FAIL aluwb got %b want %b", {bus.state_o, strobes, bus.ResultSrc}, {4'd8, 5'b00011, 2'b00});
        end
        tick();
    endtask

    task automatic test_lw;
        int seq [8]  = '{0, 1, 2, 3, 3, 3, 3, 4};
        int mr  [8]  = '{1, 0, 0, 0, 0, 0, 1, 0};
        int regw [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        int retires = 0;
        bus.op = 7'b0000011; bus.funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = mr[i][0];
            #1;
            nCompared++;
            if ({bus.state_o, bus.RegWrite} !== {seq[i][3:0], regw[i][0]}) begin
                nMismatched++;
                $display("[TB] FAIL lw_cycle%0d got state %0d regwrite %b want state %0d regwrite %0d",
                         i, bus.state_o, bus.RegWrite, seq[i], regw[i]);
            end
            if (i == 3) begin
                nCompared++;
                if ({bus.AdrSrc, bus.ResultSrc} !== 3'b100) begin
                    nMismatched++;
                    $display("[TB] FAIL lw_memread_sel got %b want 100", {bus.AdrSrc, bus.ResultSrc});
                end
            end
            if (i == 7) begin
                nCompared++;
                if (bus.ResultSrc !== 2'b01) begin
                    nMismatched++;
                    $display("[TB] FAIL lw_memwb_result got %b want 01", bus.ResultSrc);
                end
            end
            retires += int'(bus.retire);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        nCompared++;
        if (retires !== 1 || bus.state_o !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL lw_retire got %0d retires state %0d want 1 retire state 0", retires, bus.state_o);
        end
    endtask

    task automatic test_andn;
        bus.op = 7'b0001011; bus.funct7lo = 2'b00; bus.funct3 = 3'b000; bus.mem_ready = 1'b1;
        tick(); tick(); #1;
        nCompared++;
        if ({bus.state_o, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB} !== {4'd6, 4'b0110, 2'b10, 2'b00}) begin
            nMismatched++;
            $display("[TB] FAIL andn_execr got %b want %b",
                     {bus.state_o, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB}, {4'd6, 4'b0110, 2'b10, 2'b00});
        end
        tick(); #1;
        nCompared++;
        if ({bus.state_o, strobes} !== {4'd8, 5'b00011}) begin
            nMismatched++;
            $display("[TB] FAIL andn_aluwb got %b want %b", {bus.state_o, strobes}, {4'd8, 5'b00011});
        end
        tick(); #1;
        nCompared++;
        if (bus.state_o !== 4'd0) begin
            nMismatched++;
            $display("[TB] FAIL andn_length got state %0d want 0", bus.state_o);
        end
    endtask

    task automatic test_alu_decode;
        alu_vec_t tbl [17] = '{
            '{7'b0110011, 2'b00, 1'b0, 3'b000, 4'b0000, 4'd6},
            '{7'b0110011, 2'b00, 1'b1, 3'b000, 4'b0001, 4'd6},
            '{7'b0010011, 2'b00, 1'b1, 3'b000, 4'b0000, 4'd7},
            '{7'b0110011, 2'b00, 1'b0, 3'b010, 4'b0101, 4'd6},
            '{7'b0010011, 2'b00, 1'b0, 3'b110, 4'b0011, 4'd7},
            '{7'b0110011, 2'b00, 1'b0, 3'b111, 4'b0010, 4'd6},
            '{7'b0110011, 2'b00, 1'b0, 3'b100, 4'b0000, 4'd6},
            '{7'b0001011, 2'b00, 1'b0, 3'b001, 4'b0111, 4'd6},
            '{7'b0001011, 2'b00, 1'b0, 3'b010, 4'b1000, 4'd6},
            '{7'b0001011, 2'b01, 1'b0, 3'b000, 4'b1001, 4'd6},
            '{7'b0001011, 2'b01, 1'b0, 3'b001, 4'b1010, 4'd6},
            '{7'b0001011, 2'b01, 1'b0, 3'b010, 4'b1011, 4'd6},
            '{7'b0001011, 2'b01, 1'b0, 3'b011, 4'b1100, 4'd6},
            '{7'b0001011, 2'b10, 1'b0, 3'b000, 4'b1101, 4'd6},
            '{7'b0001011, 2'b10, 1'b0, 3'b001, 4'b1110, 4'd6},
            '{7'b0001011, 2'b10, 1'b0, 3'b010, 4'b1111, 4'd6},
            '{7'b0001011, 2'b10, 1'b1, 3'b000, 4'b1101, 4'd6}
        };
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.op = tbl[i].op; bus.funct7lo = tbl[i].f7lo;
            bus.funct7b5 = tbl[i].f7b5; bus.funct3 = tbl[i].f3;
            tick(); tick(); #1;
            nCompared++;
            if ({bus.state_o, bus.ALUControl} !== {tbl[i].st, tbl[i].alu}) begin
                nMismatched++;
                $display("[TB] FAIL alu_decode%0d got state %0d alu %b want state %0d alu %b",
                         i, bus.state_o, bus.ALUControl, tbl[i].st, tbl[i].alu);
            end
            tick(); tick();
        end
        bus.funct7b5 = 1'b0;
    endtask

    task automatic test_beq;
        logic zs [2] = '{1'b1, 1'b0};
        bus.op = 7'b1100011; bus.funct3 = 3'b000; bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(); tick();
            bus.Zero = zs[i];
            #1;
            nCompared++;
            if ({bus.state_o, bus.PCWrite, bus.ALUControl, bus.retire, bus.ALUSrcA, bus.ALUSrcB} !==
                {4'd9, zs[i], 4'b0001, 1'b1, 2'b10, 2'b00}) begin
                nMismatched++;
                $display("[TB] FAIL beq_zero%0d got %b want %b", zs[i],
                         {bus.state_o, bus.PCWrite, bus.ALUControl, bus.retire, bus.ALUSrcA, bus.ALUSrcB},
                         {4'd9, zs[i], 4'b0001, 1'b1, 2'b10, 2'b00});
            end
            tick(); #1;
            nCompared++;
            if (bus.state_o !== 4'd0) begin
                nMismatched++;
                $display("[TB] FAIL beq_return got state %0d want 0", bus.state_o);
            end
        end
        bus.Zero = 1'b0;
    endtask

    task automatic test_sw;
        bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick(); #1;
        nCompared++;
        if ({bus.state_o, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB} !== {4'd2, 2'b01, 2'b10, 2'b01}) begin
            nMismatched++;
            $display("[TB] FAIL sw_memadr got %b want %b",
                     {bus.state_o, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB}, {4'd2, 2'b01, 2'b10, 2'b01});
        end
        tick(); #1;
        nCompared++;
        if ({bus.state_o, bus.MemWrite, bus.AdrSrc, bus.retire} !== {4'd5, 3'b110}) begin
            nMismatched++;
            $display("[TB] FAIL sw_wait got %b want %b", {bus.state_o, bus.MemWrite, bus.AdrSrc, bus.retire}, {4'd5, 3'b110});
        end
        tick();
        bus.mem_ready = 1'b1;
        #1;
        nCompared++;
        if ({bus.state_o, bus.MemWrite, bus.AdrSrc, bus.retire} !== {4'd5, 3'b111}) begin
            nMismatched++;
            $display("[TB] FAIL sw_done got %b want %b", {bus.state_o, bus.MemWrite, bus.AdrSrc, bus.retire}, {4'd5, 3'b111});
        end
        tick(); #1;
        nCompared++;
        if ({bus.state_o, bus.MemWrite} !== {4'd0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL sw_return got %b want %b", {bus.state_o, bus.MemWrite}, {4'd0, 1'b0});
        end
    endtask

    task automatic test_jal;
        bus.op = 7'b1101111; bus.mem_ready = 1'b1;
        tick(); tick(); #1;
        nCompared++;
        if ({bus.state_o, bus.PCWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite} !==
            {4'd10, 1'b1, 2'b01, 2'b10, 4'b0000, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL jal got %b want %b",
                     {bus.state_o, bus.PCWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite},
                     {4'd10, 1'b1, 2'b01, 2'b10, 4'b0000, 1'b0});
        end
        tick(); #1;
        nCompared++;
        if ({bus.state_o, strobes} !== {4'd8, 5'b00011}) begin
            nMismatched++;
            $display("[TB] FAIL jal_aluwb got %b want %b", {bus.state_o, strobes}, {4'd8, 5'b00011});
        end
        tick();
    endtask

    task automatic test_reset_mid;
        bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        nCompared++;
        if ({bus.state_o, strobes} !== 9'd0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_strobes got %b want %b", {bus.state_o, strobes}, 9'd0);
        end
        bus.mem_ready = 1'b1;
        tick(); #1;
        nCompared++;
        if ({bus.state_o, strobes} !== 9'd0) begin
            nMismatched++;
            $display("[TB] FAIL midreset_memready got %b want %b", {bus.state_o, strobes}, 9'd0);
        end
        reset = 1'b1;
        #1;
        nCompared++;
        if ({bus.state_o, strobes} !== {4'd0, 5'b11000}) begin
            nMismatched++;
            $display("[TB] FAIL midreset_refetch got %b want %b", {bus.state_o, strobes}, {4'd0, 5'b11000});
        end
        repeat (4) tick();
    endtask

    task automatic test_illegal;
        logic [6:0] ops [3] = '{7'b1111111, 7'b0001011, 7'b0001011};
        logic [1:0] f7s [3] = '{2'b00, 2'b11, 2'b00};
        logic [2:0] f3s [3] = '{3'b000, 3'b000, 3'b011};
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.op = ops[i]; bus.funct7lo = f7s[i]; bus.funct3 = f3s[i];
            tick(); #1;
`ifdef RVX10_ILLEGAL_TRAP_EN
            nCompared++;
            if ({bus.state_o, bus.retire} !== {4'd1, 1'b0}) begin
                nMismatched++;
                $display("[TB] FAIL illegal%0d_decode got %b want %b", i, {bus.state_o, bus.retire}, {4'd1, 1'b0});
            end
            tick(); #1;
            nCompared++;
            if ({bus.state_o, strobes} !== {4'd11, 5'b0}) begin
                nMismatched++;
                $display("[TB] FAIL illegal%0d_trap got %b want %b", i, {bus.state_o, strobes}, {4'd11, 5'b0});
            end
            repeat (3) tick();
            #1;
            nCompared++;
            if ({bus.state_o, strobes} !== {4'd11, 5'b0}) begin
                nMismatched++;
                $display("[TB] FAIL illegal%0d_hold got %b want %b", i, {bus.state_o, strobes}, {4'd11, 5'b0});
            end
            reset = 1'b0;
            tick();
            reset = 1'b1;
`else
            nCompared++;
            if ({bus.state_o, bus.retire} !== {4'd1, 1'b1}) begin
                nMismatched++;
                $display("[TB] FAIL illegal%0d_decode got %b want %b", i, {bus.state_o, bus.retire}, {4'd1, 1'b1});
            end
            tick(); #1;
            nCompared++;
            if ({bus.state_o, strobes} !== {4'd0, 5'b11000}) begin
                nMismatched++;
                $display("[TB] FAIL illegal%0d_nop got %b want %b", i, {bus.state_o, strobes}, {4'd0, 5'b11000});
            end
`endif
        end
    endtask

    initial begin
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.funct7lo = 2'd0;
        bus.Zero = 1'b0; bus.mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_andn();
        test_alu_decode();
        test_beq();
        test_sw();
        test_jal();
        test_reset_mid();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
